// File: rtl/sipo_product_collector.sv
// sipo_product_collector: LSB-first serial-to-parallel collector with a double-buffered valid/ready output
module sipo_product_collector #(
    parameter int M = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   serial_in,
    input  logic                   serial_valid,
    output logic                   serial_ready,
    output logic [M-1:0]           data_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(M)-1:0]   bit_count
);
    localparam int CW = $clog2(M);
    logic [M-1:0]  shreg_q, shreg_d, data_q, data_d, shifted;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ov_q, ov_d, last, acc, done;
    // Next-state: shift accepted bits in from the top, publish a frame on its last bit
    always_comb begin
        last         = cnt_q == CW'(M - 1);
        serial_ready = !(ov_q && !out_ready && last);
        acc          = serial_valid && serial_ready && !clear;
        done         = acc && last;
        shifted      = {serial_in, shreg_q[M-1:1]};
        shreg_d      = clear ? '0 : acc ? shifted : shreg_q;
        cnt_d        = clear ? '0 : acc ? (last ? '0 : cnt_q + CW'(1)) : cnt_q;
        data_d       = done ? shifted : data_q;
        ov_d         = done ? 1'b1 : (ov_q && out_ready) ? 1'b0 : ov_q;
    end
    // State registers; reset drops any partial frame and the pending output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            ov_q    <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ov_q    <= ov_d;
        end
    end
    assign data_out  = data_q;
    assign out_valid = ov_q;
    assign bit_count = cnt_q;
endmodule

// File: tb/tb_sipo_product_collector.sv
// tb_sipo_product_collector: directed vectors and corner-case sequences for the serial collector
module tb_sipo_product_collector;
    logic        clk, rst, clear, serial_in, serial_valid, serial_ready, out_valid, out_ready;
    logic [15:0] data_out;
    logic [3:0]  bit_count;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        sr_drop;

    typedef struct {
        logic [15:0] word;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[6];

    sipo_product_collector #(.M(16)) dut (
        .clk(clk), .rst(rst), .clear(clear), .serial_in(serial_in),
        .serial_valid(serial_valid), .serial_ready(serial_ready),
        .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
        .bit_count(bit_count)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one bit for one cycle; return at the next falling edge
    task automatic push(input logic b);
        serial_in    = b;
        serial_valid = 1;
        @(negedge clk);
        serial_valid = 0;
    endtask

    task automatic send_bits(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) push(w[i]);
    endtask

    // Push with up to two idle cycles before, recording any serial_ready drop
    task automatic gap_push(input logic b);
        int g;
        g = $urandom_range(0, 2);
        for (int i = 0; i < g; i++) begin
            if (!serial_ready) sr_drop = 1;
            @(negedge clk);
        end
        if (!serial_ready) sr_drop = 1;
        push(b);
    endtask

    initial begin
        vecs[0] = '{16'hA5C3, 16'hA5C3};
        vecs[1] = '{16'hFFFF, 16'hFFFF};
        vecs[2] = '{16'h0001, 16'h0001};
        vecs[3] = '{16'h8000, 16'h8000};
        vecs[4] = '{16'h1234, 16'h1234};
        vecs[5] = '{16'h0000, 16'h0000};
        rst = 0; clear = 0; serial_in = 0; serial_valid = 0; out_ready = 1;
        #3;
        check("reset out_valid", 32'(out_valid), 0);
        check("reset data_out", 32'(data_out), 0);
        check("reset bit_count", 32'(bit_count), 0);
        check("reset serial_ready", 32'(serial_ready), 1);
        @(negedge clk);
        rst = 1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            send_bits(vecs[v].word, 16);
            check($sformatf("vec%0d out_valid", v), 32'(out_valid), 1);
            check($sformatf("vec%0d data_out", v), 32'(data_out), 32'(vecs[v].exp));
            check($sformatf("vec%0d bit_count", v), 32'(bit_count), 0);
            @(negedge clk);
            check($sformatf("vec%0d out_valid drop", v), 32'(out_valid), 0);
        end

        out_ready = 0;
        send_bits(16'hA5C3, 16);
        check("bp first valid", 32'(out_valid), 1);
        send_bits(16'h1234, 15);
        check("bp bit_count 15", 32'(bit_count), 15);
        check("bp serial_ready low", 32'(serial_ready), 0);
        check("bp data held", 32'(data_out), 32'h A5C3);
        serial_in = 0; serial_valid = 1;
        @(negedge clk);
        check("bp stall count", 32'(bit_count), 15);
        check("bp stall data", 32'(data_out), 32'hA5C3);
        out_ready = 1;
        #1;
        check("bp ready follows out_ready", 32'(serial_ready), 1);
        @(negedge clk);
        serial_valid = 0;
        check("bp second valid", 32'(out_valid), 1);
        check("bp second data", 32'(data_out), 32'h1234);
        check("bp count wrap", 32'(bit_count), 0);
        @(negedge clk);
        check("bp drained", 32'(out_valid), 0);

        sr_drop = 0;
        for (int i = 0; i < 16; i++) gap_push(1'b1);
        check("b2b first valid", 32'(out_valid), 1);
        check("b2b first data", 32'(data_out), 32'hFFFF);
        gap_push(1'b1);
        check("b2b first consumed", 32'(out_valid), 0);
        for (int i = 1; i < 16; i++) gap_push(1'b0);
        check("b2b second valid", 32'(out_valid), 1);
        check("b2b second data", 32'(data_out), 32'h0001);
        check("b2b serial_ready never dropped", 32'(sr_drop), 0);
        @(negedge clk);
        check("b2b drained", 32'(out_valid), 0);

        send_bits(16'h007F, 7);
        check("clr count before", 32'(bit_count), 7);
        clear = 1; serial_in = 1; serial_valid = 1;
        #1;
        check("clr serial_ready", 32'(serial_ready), 1);
        @(negedge clk);
        clear = 0; serial_valid = 0;
        check("clr count after", 32'(bit_count), 0);
        check("clr no spurious frame", 32'(out_valid), 0);
        send_bits(16'h8000, 16);
        check("clr frame valid", 32'(out_valid), 1);
        check("clr frame data", 32'(data_out), 32'h8000);
        @(negedge clk);

        out_ready = 0;
        send_bits(16'hAAAA, 16);
        send_bits(16'h0000, 9);
        check("rst pre count", 32'(bit_count), 9);
        check("rst pre valid", 32'(out_valid), 1);
        #2 rst = 0;
        #1;
        check("async rst out_valid", 32'(out_valid), 0);
        check("async rst data_out", 32'(data_out), 0);
        check("async rst bit_count", 32'(bit_count), 0);
        @(negedge clk);
        rst = 1;
        @(negedge clk);

        send_bits(16'hAAAA, 16);
        check("same pending data", 32'(data_out), 32'hAAAA);
        send_bits(16'h5555, 15);
        check("same still pending", 32'(data_out), 32'hAAAA);
        out_ready = 1;
        push(1'b0);
        check("same valid kept", 32'(out_valid), 1);
        check("same new data", 32'(data_out), 32'h5555);
        @(negedge clk);
        check("same drained", 32'(out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
